// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and helpers for the first-word-fall-through FIFO.
//   OUTBUF_ENTRIES : number of slots in the output buffer (head + skid)
//   fifo_is_pow2   : elaboration-time check for legal RAM depths
package fifo_pkg;

    localparam int OUTBUF_ENTRIES = 2;

    function automatic bit fifo_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_simple_dual_port.sv
// ram_simple_dual_port
// Simple dual-port RAM: one write port, one read port with registered output.
// Contents are not reset.
//   WR_CLK, WR_EN, WR_ADDR, WR_DATA : write port
//   RD_CLK, RD_EN, RD_ADDR          : read request
//   RD_DATA                         : read data, valid the cycle after RD_EN
module ram_simple_dual_port #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             WR_CLK,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_CLK,
    input  logic             RD_EN,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [WIDTH-1:0] RD_DATA
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge WR_CLK) begin
        if (WR_EN) r_mem[WR_ADDR] <= WR_DATA;
    end

    always_ff @(posedge RD_CLK) begin
        if (RD_EN) RD_DATA <= r_mem[RD_ADDR];
    end

endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft
// Single-clock first-word-fall-through FIFO. Entries live in a simple
// dual-port RAM; the RAM's registered read data is pulled ahead into a
// two-slot output buffer (head + skid) so OUT_DATA is presented without a
// read request. Total capacity is DEPTH + 2.
//   CLK, RST                        : clock, async active-high reset
//   IN_VALID, IN_READY, IN_DATA     : producer handshake
//   OUT_VALID, OUT_READY, OUT_DATA  : consumer handshake (OUT_DATA registered)
//   COUNT                           : entries held (RAM + in-flight + buffer)
//   EMPTY                           : COUNT == 0
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 32,
    localparam int DEPTH_LOG = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 3)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [CNT_W-1:0] COUNT,
    output logic             EMPTY
);

    if (!fifo_is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_fwft: DEPTH must be a power of two and >= 2");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } slot_t;

    localparam logic [DEPTH_LOG:0] RAM_FULL = (DEPTH_LOG + 1)'(DEPTH);

    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_ram_cnt;
    logic                 r_inflight;
    slot_t                r_head;
    slot_t                r_skid;
    logic [CNT_W-1:0]     r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic [2:0]           w_occ;
    logic [2:0]           w_occ_after;
    logic [WIDTH-1:0]     w_rd_data;
    slot_t                w_rd_slot;

    assign IN_READY  = !RST && (r_ram_cnt != RAM_FULL);
    assign w_push    = IN_VALID && IN_READY;
    assign w_pop     = r_head.valid && OUT_READY;

    // Slots committed to the output side, including a read still in the RAM
    // pipeline. A read is issued only if its data is sure to find a free slot.
    assign w_occ       = 3'(r_head.valid) + 3'(r_skid.valid) + 3'(r_inflight);
    assign w_occ_after = w_occ - 3'(w_pop);
    assign w_issue     = (r_ram_cnt != '0) && (w_occ_after < 3'(OUTBUF_ENTRIES));

    assign w_rd_slot = '{valid: 1'b1, data: w_rd_data};

    ram_simple_dual_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .WR_CLK  (CLK),
        .WR_EN   (w_push),
        .WR_ADDR (r_wr_ptr),
        .WR_DATA (IN_DATA),
        .RD_CLK  (CLK),
        .RD_EN   (w_issue),
        .RD_ADDR (r_rd_ptr),
        .RD_DATA (w_rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_inflight <= w_issue;

            if (w_push && !w_issue)      r_ram_cnt <= r_ram_cnt + 1'b1;
            else if (!w_push && w_issue) r_ram_cnt <= r_ram_cnt - 1'b1;

            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            // Returning read data goes to the head when the head is free after
            // this edge, otherwise to the skid. Skid always drains into head first.
            if (w_pop) begin
                if (r_skid.valid) begin
                    r_head <= r_skid;
                    if (r_inflight) r_skid <= w_rd_slot;
                    else            r_skid.valid <= 1'b0;
                end else if (r_inflight) begin
                    r_head <= w_rd_slot;
                end else begin
                    r_head.valid <= 1'b0;
                end
            end else if (r_inflight) begin
                if (!r_head.valid) r_head <= w_rd_slot;
                else               r_skid <= w_rd_slot;
            end
        end
    end

    assign OUT_VALID = r_head.valid;
    assign OUT_DATA  = r_head.data;
    assign COUNT     = r_count;
    assign EMPTY     = (r_count == '0);

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO controller with valid/ready handshakes on both sides.
- Storage is one `ram_simple_dual_port` instance with WR_CLK and RD_CLK both tied to CLK.
- The block drives the RAM write port from the upstream producer. It consumes the RAM's registered read data into a 2-entry output buffer so that OUT_DATA is presented without a read request.
- Sits between a streaming producer and a consumer in the datapath as the team's standard elastic buffer.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, RAM entries; must be a power of two and >= 2 (elaboration-time assertion).
- DEPTH_LOG, $clog2(DEPTH), RAM address width.
- CNT_W, $clog2(DEPTH+3), width of COUNT.

Ports:
- CLK  input  1  single clock for all logic and both RAM ports.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  producer has data.
- IN_READY  output  1  FIFO accepts data; handshake when IN_VALID && IN_READY.
- IN_DATA  input  WIDTH  write data.
- OUT_VALID  output  1  OUT_DATA holds the oldest entry.
- OUT_READY  input  1  consumer takes data; pop when OUT_VALID && OUT_READY.
- OUT_DATA  output  WIDTH  head-of-FIFO data, registered.
- COUNT  output  CNT_W  total entries held: RAM + in-flight read + output buffer.
- EMPTY  output  1  COUNT == 0.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0.
  - Out/skid valid bits=0, OUT_VALID=0, OUT_DATA=0, COUNT=0, EMPTY=1, IN_READY=0 while RST is high.
  - RAM contents are not reset. Reset mid-operation discards all entries; the first post-reset output is the first post-reset write.
- Write side:
  - IN_READY = !RST && (ram_cnt != DEPTH), combinational from registers.
  - On handshake: RAM WR_EN=1, WR_ADDR=wr_ptr, WR_DATA=IN_DATA; wr_ptr increments modulo DEPTH (natural wrap).
  - IN_VALID while IN_READY=0 is ignored; no state change.
- Read side:
  - Output buffer is 2 entries: a head register (drives OUT_DATA/OUT_VALID) and a skid register.
  - occ = head_v + skid_v + inflight.
  - Issue a RAM read (RD_EN=1, RD_ADDR=rd_ptr) when ram_cnt != 0 && (occ - pop) < 2, where pop = OUT_VALID && OUT_READY in the same cycle.
  - On issue, rd_ptr increments modulo DEPTH and inflight is set for the next cycle.
  - Cycle after issue: RAM RD_DATA is valid. Load it into head if head is empty or being popped and skid is empty; otherwise load it into skid.
  - On pop with skid valid, skid moves to head.
  - Ordering is strictly preserved.
- ram_cnt: +1 on write handshake, -1 on read issue; both in one cycle leaves it unchanged.
- Simultaneous write and read issue at a full or empty RAM boundary:
  - Reads only target entries already counted in ram_cnt at the start of the cycle, so there is never a same-address read/write hazard.
  - A write into a RAM with ram_cnt==DEPTH is impossible because IN_READY=0.
- Latency: a write handshake in cycle 0 into an empty FIFO gives RD_EN in cycle 1, RD_DATA in cycle 2, and OUT_VALID=1 in cycle 3.
- Throughput: sustained 1 write + 1 pop per cycle once primed. A held-off consumer never loses data.
- Capacity: DEPTH+2 entries. IN_READY drops only when the RAM itself holds DEPTH entries.
- COUNT is registered and updated on the same edge as the handshakes. Its maximum value is DEPTH+2.
- OUT_DATA holds its value while OUT_VALID && !OUT_READY; it changes only on a pop or a head load.

Decomposition:
- Package `fifo_pkg`:
  - function checking power-of-two DEPTH, used by the elaboration assertion.
  - localparam OUTBUF_ENTRIES = 2.
  - typedef for the buffer-slot struct {logic valid; logic [WIDTH-1:0] data} (parameterised via the module's local typedef).
- Sub-module: one instance of `ram_simple_dual_port` (WIDTH, DEPTH). No other sub-modules; the output buffer stays inline.

Test Plan:
- Reset then single write 0xA5A5_0001 with OUT_READY=1 -> OUT_VALID rises exactly 3 cycles after the handshake with OUT_DATA=0xA5A5_0001; COUNT goes 1 then 0; EMPTY returns to 1.
- DEPTH=32, OUT_READY=0, write 40 incrementing words -> IN_READY falls after 34 accepted; COUNT=34; OUT_DATA=0 (first word). Then drain -> words 0..33 in order with no gaps once streaming.
- Continuous IN_VALID=1 / OUT_READY=1 for 200 words -> after 3-cycle priming, one output per cycle; pointers wrap 6 times; output sequence is identical to input.
- Random OUT_READY (50%) and IN_VALID (70%) for 5000 cycles, scoreboard compare -> no loss, duplication or reorder; COUNT never exceeds 34; OUT_DATA stable while stalled.
- Fill to 20 entries, assert RST for 1 cycle asynchronously mid-stream -> OUT_VALID=0, COUNT=0, IN_READY=0 immediately; after release, first output is the first post-reset write.
- IN_VALID held while full, then a single pop -> exactly one extra write is accepted on the cycle after ram_cnt drops; the rejected-cycle data never appears at the output.
